// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external multiplier between two requesters:
// registers the selected operands, waits MUL_LAT cycles, captures the product.
module mul_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               sel,
  output logic               busy,
  output logic [2*WIDTH-1:0] p,
  output logic               done0,
  output logic               done1,
  output logic               state_dbg
);

  // Handshake: a requester holds reqN high until it sees a one-cycle doneN;
  // a req still high in the done cycle counts as a fresh request.
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam logic [2:0] LAT_C = 3'(MUL_LAT);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               sel_q, sel_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               grant;

  // On a tie the requester that was not served last wins.
  assign grant = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    p_d     = p_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = grant;
          mul_a_d = grant ? a1 : a0;
          mul_b_d = grant ? b1 : b0;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          last_d  = grant;
          state_d = MUL;
        end
      end
      default: begin
        if (cnt_q == LAT_C) begin
          p_d     = mul_p;
          done0_d = ~sel_q;
          done1_d = sel_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      p_q     <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      p_q     <= p_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign p         = p_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign state_dbg = (state_q == MUL);

endmodule
